down_counter_par_load: RTL and testbench
========================================

# down_counter_par_load

Loadable binary down counter with a reload register, borrow output and a one-shot/auto-reload terminal-count FSM. It is the count-down counterpart of the team's 4-bit up counter with parallel load. It serves as a programmable interval timer or event down-counter in register/counter datapaths. The borrow output chains into the count enable of the next stage, in the same way the up counter's carry chains.

## Interface
- WIDTH, 4, counter, data and reload-register width (≥2)
- CLK  input  1  clock; all state changes on the rising edge
- Clear  input  1  synchronous active-high reset; dominates all other inputs
- Data_in  input  WIDTH  parallel load value
- Load  input  1  active high; loads A_count and the reload register
- Count  input  1  active high; decrement enable
- Auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at each terminal-count event
- A_count  output  WIDTH  current count (registered)
- B_out  output  1  borrow; combinational; asserted in a cycle whose edge consumes a terminal count
- Done  output  1  registered pulse, one cycle after each B_out cycle
- Expired  output  1  registered, sticky; one-shot finished

## Operation
- FSM states are IDLE, ARMED and EXPIRED.
- On Clear, regardless of other inputs:
  - A_count, reload register, Done and Expired go to 0.
  - State goes to IDLE.
- Load, in any state when Clear is 0:
  - A_count and the reload register take Data_in.
  - State goes to ARMED; Expired clears.
  - Load has priority over Count; no decrement that cycle.
- In IDLE:
  - Count is ignored.
  - A_count holds 0 and B_out is 0.
- In ARMED with Count=1 and Load=0:
  - If A_count ≠ 0, A_count is decremented by 1 (mod 2^WIDTH, no carry out of width).
  - If A_count = 0, it is a terminal-count event and B_out=1:
    - With Auto_reload=1, A_count takes the reload value and the state stays ARMED.
    - With Auto_reload=0, A_count stays 0, the state goes to EXPIRED and Expired is set.
- In ARMED with Count=0, A_count holds.
- In EXPIRED:
  - Count is ignored; A_count holds 0 and B_out is 0.
  - Only Load or Clear leaves this state.
- B_out = (state==ARMED) && Count && !Load && (A_count==0). No register stage.
- Done <= B_out on every edge; it is forced to 0 on Clear.
- Reload value 0 with Auto_reload=1 is legal: B_out is asserted on every enabled cycle and A_count stays 0.
- Auto_reload may change at any time; only its value in the terminal-count cycle matters.

## Timing
- A Load of value N followed by continuous Count reaches 0 N edges later.
- B_out is asserted during the (N+1)th enabled cycle after the Load edge.
- Period in auto-reload mode is N+1 enabled cycles per B_out.
- Done follows B_out by exactly 1 cycle.
- Expired rises on the same edge as the EXPIRED transition.
- B_out is asserted in the same cycle as the qualifying inputs, so it is usable as a same-cycle enable for a cascaded stage.
- Clear mid-count:
  - Outputs are 0 on the following edge.
  - A Done pulse pending from the prior cycle is suppressed.

## Structure
- Shared package counter_pkg holds:
  - state enum typedef cnt_state_t (IDLE, ARMED, EXPIRED)
  - default width constant CNT_WIDTH_DEF = 4
- Single module; no sub-module. Zero-detect and next-count logic are combinational blocks within it.
- Reload register, A_count, state, Done and Expired live in one clocked process.

## Test plan
- Reset:
  - Assert Clear with Load=1, Data_in=4'hA -> A_count=0, state IDLE, Done=0, Expired=0.
  - Then Count=1 for 3 cycles -> A_count stays 0, B_out stays 0.
- One-shot:
  - Load 4'h3, Auto_reload=0, Count=1 held -> A_count sequence 3,2,1,0.
  - B_out=1 in the cycle at 0, Done=1 on the next cycle, Expired=1 and sticky.
  - Further Count leaves A_count at 0.
- Auto-reload:
  - Load 4'h2, Auto_reload=1, Count=1 held -> A_count 2,1,0,2,1,0,…
  - B_out every 3rd cycle; Done lags B_out by 1 cycle.
- Priority:
  - Load=1 and Count=1 together with Data_in=4'h5 while A_count=0 in ARMED -> A_count=5, B_out=0, no Done.
  - In EXPIRED, Load 4'h1 -> state ARMED, Expired=0.
- Edge cases:
  - Reload 0 with Auto_reload=1 -> B_out high on every Count cycle, A_count=0.
  - Count toggling 1,0,1 -> A_count decrements only on enabled edges.
  - Clear asserted in the B_out cycle -> next cycle has Done=0 and A_count=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the loadable down counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPIRED = 2'd2
  } cnt_state_t;

  localparam int CNT_WIDTH_DEF = 4;

endpackage : counter_pkg

// File: rtl/down_counter_par_load.sv
// Loadable down counter with reload register, same-cycle borrow and a
// one-shot / auto-reload terminal-count FSM.
//
// state   | meaning
// IDLE    | after Clear; Count ignored, count held at 0
// ARMED   | loaded; counts down on Count, borrow at zero
// EXPIRED | one-shot finished; only Load or Clear leaves
module down_counter_par_load
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             Load,
  input  logic             Count,
  input  logic             Auto_reload,
  output logic [WIDTH-1:0] A_count,
  output logic             B_out,
  output logic             Done,
  output logic             Expired
);

  cnt_state_t       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;
  logic             r_expired;

  cnt_state_t       w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_expired_nxt;
  logic             w_zero;
  logic             w_borrow;

  always_comb begin
    w_zero   = (r_count == '0);
    w_borrow = (r_state == ARMED) && Count && !Load && w_zero;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_reload_nxt  = r_reload;
    w_expired_nxt = r_expired;
    if (Load) begin
      w_count_nxt   = Data_in;
      w_reload_nxt  = Data_in;
      w_state_nxt   = ARMED;
      w_expired_nxt = 1'b0;
    end else begin
      case (r_state)
        ARMED: begin
          if (Count) begin
            if (!w_zero) begin
              w_count_nxt = r_count - 1'b1;
            end else if (Auto_reload) begin
              w_count_nxt = r_reload;
            end else begin
              w_state_nxt   = EXPIRED;
              w_expired_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // Clear dominates everything, including a Done pulse about to be issued.
  always_ff @(posedge CLK) begin
    if (Clear) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_reload  <= w_reload_nxt;
      r_done    <= w_borrow;
      r_expired <= w_expired_nxt;
    end
  end

  assign A_count = r_count;
  assign B_out   = w_borrow;
  assign Done    = r_done;
  assign Expired = r_expired;

endmodule : down_counter_par_load

// File: tb/tb_down_counter_par_load.sv
// Directed vector bench for down_counter_par_load (WIDTH = 4).
module tb_down_counter_par_load;

  logic       CLK = 1'b0;
  logic       Clear = 1'b1;
  logic [3:0] Data_in = '0;
  logic       Load = 1'b0;
  logic       Count = 1'b0;
  logic       Auto_reload = 1'b0;
  logic [3:0] A_count;
  logic       B_out;
  logic       Done;
  logic       Expired;

  int n_checks = 0;
  int n_errors = 0;

  down_counter_par_load #(.WIDTH(4)) dut (
    .CLK(CLK), .Clear(Clear), .Data_in(Data_in), .Load(Load), .Count(Count),
    .Auto_reload(Auto_reload), .A_count(A_count), .B_out(B_out),
    .Done(Done), .Expired(Expired)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       clr, ld, cnt, ar;
    logic [3:0] din;
    logic       exp_b;
    logic [3:0] exp_cnt;
    logic       exp_done, exp_expired;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic clr, ld, cnt, ar, input logic [3:0] din,
                     input logic b, input logic [3:0] c, input logic d, e);
    vec_t v;
    v.clr = clr; v.ld = ld; v.cnt = cnt; v.ar = ar; v.din = din;
    v.exp_b = b; v.exp_cnt = c; v.exp_done = d; v.exp_expired = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic clr, ld, cnt, ar, input logic [3:0] din);
    Clear = clr; Load = ld; Count = cnt; Auto_reload = ar; Data_in = din;
  endtask

  initial begin
    //   clr ld cnt ar din   b  cnt  done exp
    add(1, 1, 0, 0, 4'hA,  0, 4'h0, 0, 0);  // 0 clear beats load
    add(0, 0, 1, 0, 4'h0,  0, 4'h0, 0, 0);  // 1 idle ignores count
    add(0, 0, 1, 0, 4'h0,  0, 4'h0, 0, 0);
    add(0, 0, 1, 0, 4'h0,  0, 4'h0, 0, 0);
    add(0, 1, 0, 0, 4'h3,  0, 4'h3, 0, 0);  // 4 one-shot load 3
    add(0, 0, 1, 0, 4'h0,  0, 4'h2, 0, 0);
    add(0, 0, 1, 0, 4'h0,  0, 4'h1, 0, 0);
    add(0, 0, 1, 0, 4'h0,  0, 4'h0, 0, 0);
    add(0, 0, 1, 0, 4'h0,  1, 4'h0, 1, 1);  // 8 terminal count
    add(0, 0, 1, 0, 4'h0,  0, 4'h0, 0, 1);  // sticky expired
    add(0, 0, 1, 0, 4'h0,  0, 4'h0, 0, 1);
    add(0, 1, 1, 0, 4'h1,  0, 4'h1, 0, 0);  // 11 load from expired
    add(0, 1, 0, 1, 4'h2,  0, 4'h2, 0, 0);  // 12 auto-reload load 2
    add(0, 0, 1, 1, 4'h0,  0, 4'h1, 0, 0);
    add(0, 0, 1, 1, 4'h0,  0, 4'h0, 0, 0);
    add(0, 0, 1, 1, 4'h0,  1, 4'h2, 1, 0);
    add(0, 0, 1, 1, 4'h0,  0, 4'h1, 0, 0);
    add(0, 0, 1, 1, 4'h0,  0, 4'h0, 0, 0);
    add(0, 0, 1, 1, 4'h0,  1, 4'h2, 1, 0);
    add(0, 0, 1, 1, 4'h0,  0, 4'h1, 0, 0);
    add(0, 0, 1, 1, 4'h0,  0, 4'h0, 0, 0);
    add(0, 1, 1, 1, 4'h5,  0, 4'h5, 0, 0);  // 21 load beats count at zero
    add(0, 0, 0, 1, 4'h0,  0, 4'h5, 0, 0);
    add(0, 0, 1, 1, 4'h0,  0, 4'h4, 0, 0);  // 23 count toggling
    add(0, 0, 0, 1, 4'h0,  0, 4'h4, 0, 0);
    add(0, 0, 1, 1, 4'h0,  0, 4'h3, 0, 0);
    add(0, 1, 0, 1, 4'h0,  0, 4'h0, 0, 0);  // 26 reload value 0
    add(0, 0, 1, 1, 4'h0,  1, 4'h0, 1, 0);
    add(0, 0, 1, 1, 4'h0,  1, 4'h0, 1, 0);
    add(0, 0, 0, 1, 4'h0,  0, 4'h0, 0, 0);
    add(0, 0, 1, 1, 4'h0,  1, 4'h0, 1, 0);
    add(0, 1, 0, 0, 4'h2,  0, 4'h2, 0, 0);  // 31 clear in borrow cycle
    add(0, 0, 1, 0, 4'h0,  0, 4'h1, 0, 0);
    add(0, 0, 1, 0, 4'h0,  0, 4'h0, 0, 0);
    add(1, 0, 1, 0, 4'h0,  1, 4'h0, 0, 0);
    add(0, 0, 1, 0, 4'h0,  0, 4'h0, 0, 0);
    add(0, 1, 0, 1, 4'h1,  0, 4'h1, 0, 0);  // 36 auto_reload sampled at tc
    add(0, 0, 1, 1, 4'h0,  0, 4'h0, 0, 0);
    add(0, 0, 1, 0, 4'h0,  1, 4'h0, 1, 1);
    add(0, 1, 0, 0, 4'hF,  0, 4'hF, 0, 0);  // 39 full-scale load
    add(0, 0, 1, 0, 4'h0,  0, 4'hE, 0, 0);

    @(posedge CLK);
    @(posedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i].clr, vecs[i].ld, vecs[i].cnt, vecs[i].ar, vecs[i].din);
      #1;
      chk("B_out", i, 32'(B_out), 32'(vecs[i].exp_b));
      @(posedge CLK);
      #1;
      chk("A_count", i, 32'(A_count), 32'(vecs[i].exp_cnt));
      chk("Done", i, 32'(Done), 32'(vecs[i].exp_done));
      chk("Expired", i, 32'(Expired), 32'(vecs[i].exp_expired));
    end

    // One-shot load of 5: borrow must land on the 6th enabled cycle.
    begin
      int cycles;
      bit seen;
      cycles = 0;
      seen = 0;
      @(negedge CLK);
      drive(0, 1, 0, 0, 4'h5);
      @(negedge CLK);
      drive(0, 0, 1, 0, 4'h0);
      while (!seen && cycles < 40) begin
        #1;
        cycles++;
        if (B_out === 1'b1) seen = 1;
        @(negedge CLK);
      end
      chk("borrow_seen", 0, 32'(seen), 32'd1);
      chk("borrow_latency", 0, 32'(cycles), 32'd6);
      #1;
      chk("done_after_borrow", 0, 32'(Done), 32'd1);
      chk("expired_after_borrow", 0, 32'(Expired), 32'd1);
    end

    // Auto-reload period of 4 (reload 3): count borrows over 12 enabled cycles.
    begin
      int borrows;
      int dones;
      borrows = 0;
      dones = 0;
      @(negedge CLK);
      drive(0, 1, 0, 1, 4'h3);
      @(negedge CLK);
      drive(0, 0, 1, 1, 4'h0);
      for (int k = 0; k < 12; k++) begin
        #1;
        if (B_out === 1'b1) borrows++;
        @(posedge CLK);
        #1;
        if (Done === 1'b1) dones++;
        @(negedge CLK);
      end
      chk("autoreload_borrows", 0, 32'(borrows), 32'd3);
      chk("autoreload_dones", 0, 32'(dones), 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_down_counter_par_load
